// File: rtl/i2c_pkg.sv
// Shared constants and the event bundle handed from the line conditioner
// to the downstream I2C slave byte engine.
package i2c_pkg;

  localparam logic I2C_IDLE_LEVEL          = 1'b1;
  localparam int   I2C_FILTER_LEN_DEF      = 3;
  localparam int   I2C_TIMEOUT_CYCLES_DEF  = 50000;

  typedef struct packed {
    logic start;
    logic rstart;
    logic stop;
    logic scl_rise;
    logic scl_fall;
    logic bit_valid;
    logic bit_value;
  } i2c_event_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// One bus line: 2-flop synchronizer, run-length deglitch filter and
// edge strobes derived from the filtered level.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN = I2C_FILTER_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_prev;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= I2C_IDLE_LEVEL;
      r_sync2 <= I2C_IDLE_LEVEL;
      r_level <= I2C_IDLE_LEVEL;
      r_prev  <= I2C_IDLE_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_level;
      // Any sample agreeing with the filtered level restarts the run.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_prev;
  assign o_fall  = ~r_level & r_prev;

endmodule

// File: rtl/i2c_line_conditioner.sv
// Conditioned SCL/SDA front end: START/STOP/repeated-START decode, bus-busy
// tracking and SCL-stuck-low timeout for the slave byte engine.
module i2c_line_conditioner
  import i2c_pkg::*;
#(
  parameter int FILTER_LEN     = I2C_FILTER_LEN_DEF,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic SCL_in,
  input  logic SDA_in,
  output logic scl_level,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic bit_valid,
  output logic bit_value,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_busy,
  output logic scl_timeout
);

  localparam logic [TIMEOUT_W-1:0] TO_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic w_scl_level, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_rise, w_sda_fall;
  logic w_scl_high_stable;
  logic w_to_hit;
  i2c_event_t w_evt;

  logic                 r_busy;
  logic [TIMEOUT_W-1:0] r_to_cnt;

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clock  (clock),
    .reset  (reset),
    .i_raw  (SCL_in),
    .o_level(w_scl_level),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clock  (clock),
    .reset  (reset),
    .i_raw  (SDA_in),
    .o_level(w_sda_level),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  // SCL high now and last cycle; excludes an SCL edge coinciding with SDA.
  assign w_scl_high_stable = w_scl_level & ~w_scl_rise;

  assign w_to_hit = r_busy & ~w_scl_level & (r_to_cnt == TO_MAX);

  always_comb begin
    w_evt           = '0;
    w_evt.start     = w_sda_fall & w_scl_high_stable;
    w_evt.stop      = w_sda_rise & w_scl_high_stable;
    w_evt.rstart    = w_evt.start & r_busy;
    w_evt.scl_rise  = w_scl_rise;
    w_evt.scl_fall  = w_scl_fall;
    w_evt.bit_valid = w_scl_rise;
    w_evt.bit_value = w_scl_rise & w_sda_level;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy   <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      if (w_evt.start) begin
        r_busy <= 1'b1;
      end else if (w_evt.stop || w_to_hit) begin
        r_busy <= 1'b0;
      end
      // Saturates at the threshold; busy drops right after, clearing it.
      if (!r_busy || w_scl_level) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign scl_level   = w_scl_level;
  assign sda_level   = w_sda_level;
  assign scl_rise    = w_evt.scl_rise;
  assign scl_fall    = w_evt.scl_fall;
  assign bit_valid   = w_evt.bit_valid;
  assign bit_value   = w_evt.bit_value;
  assign start_det   = w_evt.start;
  assign rstart_det  = w_evt.rstart;
  assign stop_det    = w_evt.stop;
  assign bus_busy    = r_busy;
  assign scl_timeout = w_to_hit;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Scoreboard bench: a history-based line model predicts every strobe; a
// negedge monitor pops and compares whenever the DUT raises any strobe.
module tb_i2c_line_conditioner;
  import i2c_pkg::*;

  localparam int FL = 3;
  localparam int TO = 100;
  localparam int TW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic SCL_in = 1'b1;
  logic SDA_in = 1'b1;
  logic scl_level, sda_level, scl_rise, scl_fall, bit_valid, bit_value;
  logic start_det, rstart_det, stop_det, bus_busy, scl_timeout;

  i2c_line_conditioner #(.FILTER_LEN(FL), .TIMEOUT_W(TW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .SCL_in(SCL_in), .SDA_in(SDA_in),
    .scl_level(scl_level), .sda_level(sda_level), .scl_rise(scl_rise),
    .scl_fall(scl_fall), .bit_valid(bit_valid), .bit_value(bit_value),
    .start_det(start_det), .rstart_det(rstart_det), .stop_det(stop_det),
    .bus_busy(bus_busy), .scl_timeout(scl_timeout)
  );

  always #5 clock = ~clock;

  // ev = {start, rstart, stop, rise, fall, bit_valid, bit_value, timeout}
  typedef struct packed {
    logic [7:0] ev;
    logic       busy;
    logic       scl;
    logic       sda;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   ev_count = 0;
  int   tout_seen = 0;
  logic [7:0] rx_byte = 8'h00;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // ---------------- reference model ----------------
  logic hs[$];
  logic hd[$];
  logic m_scl, m_sda, m_scl_p, m_sda_p, m_busy;
  logic e_start, e_rstart, e_stop, e_rise, e_fall, e_bv, e_bval, e_tout;
  logic in_low;
  int   low_start;

  // Filtered level flips once the last FL synced samples all disagree with it.
  // Synced sample seen at an edge is the raw value captured two edges earlier.
  function automatic logic window_differs(input logic h[$], input logic lvl);
    for (int k = 0; k < FL; k++)
      if (h[h.size() - 3 - k] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    hs.delete();
    hd.delete();
    for (int i = 0; i < FL + 3; i++) begin
      hs.push_back(1'b1);
      hd.push_back(1'b1);
    end
    m_scl = 1; m_sda = 1; m_scl_p = 1; m_sda_p = 1; m_busy = 0;
    e_start = 0; e_rstart = 0; e_stop = 0; e_rise = 0; e_fall = 0;
    e_bv = 0; e_bval = 0; e_tout = 0;
    in_low = 0; low_start = 0;
  endtask

  always @(posedge clock) begin
    logic cond;
    exp_t e;
    cyc++;
    if (!reset) begin
      model_reset();
    end else begin
      if (e_start) m_busy = 1;
      else if (e_stop || e_tout) m_busy = 0;
      m_scl_p = m_scl;
      m_sda_p = m_sda;
      hs.push_back(SCL_in);
      hd.push_back(SDA_in);
      if (hs.size() > FL + 6) void'(hs.pop_front());
      if (hd.size() > FL + 6) void'(hd.pop_front());
      if (window_differs(hs, m_scl)) m_scl = ~m_scl;
      if (window_differs(hd, m_sda)) m_sda = ~m_sda;
      e_rise   = m_scl & ~m_scl_p;
      e_fall   = ~m_scl & m_scl_p;
      e_start  = ~m_sda & m_sda_p & m_scl & m_scl_p;
      e_stop   = m_sda & ~m_sda_p & m_scl & m_scl_p;
      e_rstart = e_start & m_busy;
      e_bv     = e_rise;
      e_bval   = e_rise & m_sda;
      cond = m_busy & ~m_scl;
      if (cond && !in_low) begin
        in_low = 1;
        low_start = cyc;
      end else if (!cond) begin
        in_low = 0;
      end
      e_tout = cond && (cyc - low_start == TO);
      e.cyc = cyc;
      e.o = '{ev: {e_start, e_rstart, e_stop, e_rise, e_fall, e_bv, e_bval, e_tout},
              busy: m_busy, scl: m_scl, sda: m_sda};
      if (e.o.ev != 8'h00) sb_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    obs_t d;
    exp_t e;
    if (reset) begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        check("missed_event", cyc, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
      d = '{ev: {start_det, rstart_det, stop_det, scl_rise, scl_fall, bit_valid, bit_value, scl_timeout},
            busy: bus_busy, scl: scl_level, sda: sda_level};
      if (d.ev != 8'h00) begin
        ev_count++;
        if (scl_timeout) tout_seen++;
        if (bit_valid) rx_byte = {rx_byte[6:0], bit_value};
        if (sb_q.size() == 0) begin
          check("extra_event", longint'(d), 0);
        end else begin
          e = sb_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_obs", longint'(d), longint'(e.o));
          $display("cyc %0d ev=%b busy=%b scl=%b sda=%b", cyc, d.ev, d.busy, d.scl, d.sda);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic set_scl(input logic v);
    @(negedge clock); SCL_in = v;
  endtask
  task automatic set_sda(input logic v);
    @(negedge clock); SDA_in = v;
  endtask
  task automatic check_state(input string tag);
    check({tag, "_busy"}, bus_busy, m_busy);
    check({tag, "_scl"}, scl_level, m_scl);
    check({tag, "_sda"}, sda_level, m_sda);
  endtask

  task automatic send_byte(input logic [7:0] b, input int half);
    for (int i = 7; i >= 0; i--) begin
      set_scl(1'b0);
      idle(half / 2);
      SDA_in = b[i];
      idle(half - half / 2);
      SCL_in = 1'b1;
      idle(half);
    end
    set_scl(1'b0);
    idle(half);
  endtask

  task automatic stop_cond(input int half);
    set_sda(1'b0); idle(half);
    set_scl(1'b1); idle(half);
    set_sda(1'b1); idle(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int half;
    int snap;
    logic [7:0] b;
    idle(3);
    check("rst_busy", bus_busy, 0);
    check("rst_levels", {scl_level, sda_level}, 2'b11);
    check("rst_strobes", {start_det, rstart_det, stop_det, scl_rise, scl_fall, bit_valid, bit_value, scl_timeout}, 0);
    @(negedge clock); reset = 1'b1;
    idle(5);

    // Short glitches on either line must vanish.
    for (int i = 0; i < 6; i++) begin
      half = $urandom_range(1, FL - 1);
      if ($urandom_range(0, 1) == 0) set_sda(1'b0); else set_scl(1'b0);
      idle(half);
      SDA_in = 1'b1; SCL_in = 1'b1;
      idle(8);
      check_state("glitch");
    end

    // Exactly FL cycles low on SDA is accepted: START, then STOP on release.
    set_sda(1'b0); idle(FL); SDA_in = 1'b1; idle(10);
    check_state("min_pulse");

    // Idle START, then bytes.
    set_sda(1'b0); idle(10);
    check_state("start");
    send_byte(8'hA5, 20);
    idle(2);
    check("byte_a5", rx_byte, 8'hA5);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom_range(0, 255));
      half = $urandom_range(8, 30);
      send_byte(b, half);
      idle(2);
      check("byte_rand", rx_byte, b);
    end

    // Repeated START while busy, then STOP.
    set_sda(1'b1); idle(10);
    set_scl(1'b1); idle(10);
    set_sda(1'b0); idle(10);
    check_state("rstart");
    set_scl(1'b0); idle(10);
    stop_cond(10);
    check_state("stop");

    // SCL stuck low with SDA chatter: one timeout only.
    snap = tout_seen;
    set_sda(1'b0); idle(10);
    set_scl(1'b0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 5) == 0) SDA_in = ~SDA_in;
    end
    check_state("timeout");
    check("timeout_count", tout_seen - snap, 1);
    // Both lines released in the same cycle: SCL edge only, no STOP.
    @(negedge clock); SDA_in = 1'b0;
    idle(10);
    @(negedge clock); SCL_in = 1'b1; SDA_in = 1'b1;
    idle(10);
    check_state("simul");

    // Reset in the middle of a byte.
    set_sda(1'b0); idle(10);
    set_scl(1'b0); idle(5);
    set_sda(1'b1); idle(5);
    set_scl(1'b1); idle(2);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("midrst_busy", bus_busy, 0);
    check("midrst_levels", {scl_level, sda_level}, 2'b11);
    check("midrst_strobes", {start_det, rstart_det, stop_det, scl_rise, scl_fall, bit_valid, bit_value, scl_timeout}, 0);
    sb_q.delete();
    model_reset();
    SCL_in = 1'b1; SDA_in = 1'b1;
    idle(3);
    @(negedge clock); reset = 1'b1;
    snap = ev_count;
    idle(20);
    check("post_reset_quiet", ev_count - snap, 0);
    check_state("post_reset");

    idle(10);
    check("queue_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
